// File: rtl/period_meter.sv
// period_meter: measures an asynchronous square wave in system-clock cycles.
// It reports the last full period, the high time within it and the divider
// setting that would have produced it. It also flags a stalled input.
module period_meter #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 50000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             ack,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic [WIDTH-1:0] divide_est,
   output logic             meas_valid,
   output logic             new_sample,
   output logic             stalled
);

   typedef enum logic {
      WAIT_EDGE,
      COUNT
   } state_t;

   localparam logic [WIDTH-1:0] TimeoutCount = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] AllOnes      = '1;
   localparam logic [WIDTH-1:0] One          = WIDTH'(1);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   sDlyQ;
   logic                   sigSync;
   logic                   rise;
   logic                   fall;

   state_t                 stateQ, stateD;
   logic [WIDTH-1:0]       cntQ, cntD;
   logic [WIDTH-1:0]       cntInc;
   logic [WIDTH-1:0]       hiLatQ, hiLatD;
   logic [WIDTH-1:0]       periodQ, periodD;
   logic [WIDTH-1:0]       highTimeQ, highTimeD;
   logic [WIDTH-1:0]       divideQ, divideD;
   logic                   measValidQ, measValidD;
   logic                   newSampleQ, newSampleD;
   logic                   stalledQ, stalledD;
   logic                   timeoutHit;

   // Bring sig_in into the clk domain and keep one delayed copy for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncQ <= '0;
         sDlyQ <= 1'b0;
      end else begin
         syncQ <= {syncQ[SYNC_STAGES-2:0], sig_in};
         sDlyQ <= syncQ[SYNC_STAGES-1];
      end
   end

   assign sigSync = syncQ[SYNC_STAGES-1];
   assign rise    = sigSync & ~sDlyQ;
   assign fall    = ~sigSync & sDlyQ;

   // The length so far includes the current cycle; it sticks at all-ones instead of wrapping.
   assign cntInc     = (cntQ == AllOnes) ? cntQ : cntQ + One;
   assign timeoutHit = (TIMEOUT != 0) && (cntInc == TimeoutCount) && !rise;

   // Next-state logic: track edges, latch measurements on rise and fall back to waiting on a stall.
   always_comb begin
      stateD     = stateQ;
      cntD       = cntQ;
      hiLatD     = hiLatQ;
      periodD    = periodQ;
      highTimeD  = highTimeQ;
      divideD    = divideQ;
      measValidD = 1'b0;
      stalledD   = stalledQ;
      newSampleD = measValidQ ? 1'b1 : (ack ? 1'b0 : newSampleQ);

      case (stateQ)
         WAIT_EDGE: begin
            cntD = '0;
            if (rise) begin
               stateD = COUNT;
            end
         end
         COUNT: begin
            cntD = rise ? '0 : cntInc;
            if (fall) begin
               hiLatD = cntInc;
            end
            if (rise) begin
               periodD    = cntInc;
               highTimeD  = hiLatQ;
               divideD    = cntInc >> 1;
               measValidD = 1'b1;
               stalledD   = 1'b0;
            end else if (timeoutHit) begin
               periodD   = '0;
               highTimeD = '0;
               divideD   = '0;
               stalledD  = 1'b1;
               cntD      = '0;
               stateD    = WAIT_EDGE;
            end
         end
         default: begin
            stateD = WAIT_EDGE;
         end
      endcase
   end

   // Measurement state and CSR-visible result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ     <= WAIT_EDGE;
         cntQ       <= '0;
         hiLatQ     <= '0;
         periodQ    <= '0;
         highTimeQ  <= '0;
         divideQ    <= '0;
         measValidQ <= 1'b0;
         newSampleQ <= 1'b0;
         stalledQ   <= 1'b0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         hiLatQ     <= hiLatD;
         periodQ    <= periodD;
         highTimeQ  <= highTimeD;
         divideQ    <= divideD;
         measValidQ <= measValidD;
         newSampleQ <= newSampleD;
         stalledQ   <= stalledD;
      end
   end

   assign period     = periodQ;
   assign high_time  = highTimeQ;
   assign divide_est = divideQ;
   assign meas_valid = measValidQ;
   assign new_sample = newSampleQ;
   assign stalled    = stalledQ;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: drives square waves into period_meter and compares every
// output, every cycle, against a model built from the input edge times.
module tb_period_meter;

   localparam int WIDTH       = 32;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 100;
   localparam int LAT         = SYNC_STAGES + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             sig_in;
   logic             ack;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic [WIDTH-1:0] divide_est;
   logic             meas_valid;
   logic             new_sample;
   logic             stalled;

   period_meter #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sig_in(sig_in),
      .ack(ack),
      .period(period),
      .high_time(high_time),
      .divide_est(divide_est),
      .meas_valid(meas_valid),
      .new_sample(new_sample),
      .stalled(stalled)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   typedef struct {
      int due;
      int per;
      int high;
   } meas_t;

   meas_t expQ[$];
   int    stallQ[$];
   int    checks = 0;
   int    errors = 0;
   int    cycleNum = 0;
   bit    armed = 0;
   bit    inReset = 0;
   int    lastRise = 0;
   int    lastFall = 0;
   int    expPeriod = 0;
   int    expHigh = 0;
   int    expDiv = 0;
   bit    expStalled = 0;
   bit    expNew = 0;
   bit    prevExpMv = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", tag, cycleNum, observed, expected);
      end
   endtask

   task automatic resetModel();
      expQ.delete();
      stallQ.delete();
      armed      = 0;
      expPeriod  = 0;
      expHigh    = 0;
      expDiv     = 0;
      expStalled = 0;
      expNew     = 0;
      prevExpMv  = 0;
   endtask

   // A rise closes a measurement if one was open and came within the timeout; else it just re-arms.
   task automatic onRise(input int t);
      meas_t m;
      if (armed) begin
         if (t - lastRise > TIMEOUT) begin
            stallQ.push_back(lastRise + LAT + TIMEOUT);
         end else begin
            m.due  = t + LAT;
            m.per  = t - lastRise;
            m.high = lastFall - lastRise;
            expQ.push_back(m);
         end
      end
      armed    = 1;
      lastRise = t;
   endtask

   task automatic setSig(input logic v);
      if (!inReset && v !== sig_in) begin
         if (v) onRise(cycleNum);
         else   lastFall = cycleNum;
      end
      sig_in = v;
   endtask

   // Advance one clock, update the model for this cycle and compare every output.
   task automatic tick();
      bit    expMv;
      meas_t m;
      @(posedge clk);
      #1;
      cycleNum++;
      expMv = 0;
      if (inReset) begin
         resetModel();
      end else begin
         if (expQ.size() > 0 && expQ[0].due == cycleNum) begin
            m          = expQ.pop_front();
            expMv      = 1;
            expPeriod  = m.per;
            expHigh    = m.high;
            expDiv     = m.per / 2;
            expStalled = 0;
         end else if (stallQ.size() > 0 && stallQ[0] == cycleNum) begin
            void'(stallQ.pop_front());
            expPeriod  = 0;
            expHigh    = 0;
            expDiv     = 0;
            expStalled = 1;
         end else if (armed && cycleNum == lastRise + LAT + TIMEOUT) begin
            expPeriod  = 0;
            expHigh    = 0;
            expDiv     = 0;
            expStalled = 1;
            armed      = 0;
         end
         expNew = prevExpMv ? 1'b1 : (ack ? 1'b0 : expNew);
      end
      prevExpMv = expMv;
      checkOutput("meas_valid", meas_valid, expMv);
      checkOutput("period", period, expPeriod);
      checkOutput("high_time", high_time, expHigh);
      checkOutput("divide_est", divide_est, expDiv);
      checkOutput("stalled", stalled, expStalled);
      checkOutput("new_sample", new_sample, expNew);
   endtask

   task automatic applyStimulus(input int high, input int low);
      setSig(1'b1);
      repeat (high) tick();
      setSig(1'b0);
      repeat (low) tick();
   endtask

   // Assert reset between clock edges, confirm the outputs clear at once, then release.
   task automatic applyReset(input int cycles);
      #2;
      reset   = 1'b1;
      inReset = 1;
      #1;
      checkOutput("async period", period, 0);
      checkOutput("async high_time", high_time, 0);
      checkOutput("async divide_est", divide_est, 0);
      checkOutput("async meas_valid", meas_valid, 0);
      checkOutput("async new_sample", new_sample, 0);
      checkOutput("async stalled", stalled, 0);
      resetModel();
      repeat (cycles) tick();
      reset   = 1'b0;
      inReset = 0;
      if (sig_in) onRise(cycleNum);
   endtask

   initial begin
      reset   = 1'b1;
      inReset = 1;
      sig_in  = 1'b0;
      ack     = 1'b0;
      repeat (3) tick();
      reset   = 1'b0;
      inReset = 0;
      repeat (4) tick();

      $display("[TB] symmetric 5/5 input");
      repeat (6) applyStimulus(5, 5);

      $display("[TB] asymmetric input");
      repeat (3) applyStimulus(3, 7);
      repeat (3) applyStimulus(4, 7);

      $display("[TB] timeout and restart");
      repeat (3) applyStimulus(5, 5);
      repeat (TIMEOUT + 10) tick();
      repeat (4) applyStimulus(4, 4);

      $display("[TB] period exactly at and just past the timeout");
      applyStimulus(5, 5);
      applyStimulus(50, 50);
      applyStimulus(51, 50);
      repeat (3) applyStimulus(5, 5);

      $display("[TB] acknowledge handling");
      repeat (2) applyStimulus(5, 5);
      setSig(1'b1);
      repeat (LAT) tick();
      ack = 1'b1;
      tick();
      tick();
      ack = 1'b0;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (4) tick();
      setSig(1'b0);
      repeat (10) tick();
      applyStimulus(5, 5);

      $display("[TB] reset mid-measurement");
      repeat (3) applyStimulus(5, 5);
      setSig(1'b1);
      repeat (2) tick();
      setSig(1'b0);
      repeat (3) tick();
      applyReset(3);
      repeat (3) tick();
      repeat (3) applyStimulus(5, 5);

      $display("[TB] period change 10 to 6");
      repeat (4) applyStimulus(5, 5);
      repeat (5) applyStimulus(3, 3);

      $display("[TB] input held high through reset release");
      setSig(1'b1);
      repeat (2) tick();
      applyReset(4);
      repeat (6) tick();
      setSig(1'b0);
      repeat (5) tick();
      repeat (3) applyStimulus(5, 5);

      $display("[TB] random waveforms with random acknowledges");
      for (int i = 0; i < 25; i++) begin
         int h;
         int l;
         h = int'($urandom_range(2, 20));
         l = int'($urandom_range(2, 20));
         setSig(1'b1);
         for (int j = 0; j < h; j++) begin
            ack = ($urandom_range(0, 3) == 0);
            tick();
         end
         setSig(1'b0);
         for (int j = 0; j < l; j++) begin
            ack = ($urandom_range(0, 3) == 0);
            tick();
         end
      end
      ack = 1'b0;
      repeat (10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
